// File: rtl/cache_refill_ctrl_pkg.sv
// cache_refill_ctrl_pkg
// Shared constants, the refill state encoding and the line-address helper
// for the cache miss/refill controller.
//   INDEX_WIDTH : set index width (128 sets)
//   TAG_WIDTH   : tag width
//   LINE_WIDTH  : cache line width in bits
//   WAYS        : associativity, WAY_WIDTH bits select a way
package cache_refill_ctrl_pkg;

  localparam int INDEX_WIDTH = 7;
  localparam int TAG_WIDTH   = 19;
  localparam int LINE_WIDTH  = 128;
  localparam int WAYS        = 4;
  localparam int WAY_WIDTH   = $clog2(WAYS);
  localparam int ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_FILL
  } refill_state_e;

  // Memory addresses whole lines: the tag sits above the set index.
  function automatic logic [ADDR_WIDTH-1:0] line_addr(
    input logic [TAG_WIDTH-1:0]   tag,
    input logic [INDEX_WIDTH-1:0] idx
  );
    return {tag, idx};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
// Miss handler for the 4-way set-associative cache. Queries the LRU victim
// of the missing set, writes it back when dirty, fetches the missing line,
// fills the victim way and marks it most-recently-used. Outside the fill
// cycle the LRU update port forwards hit touches from the lookup pipeline.
// Ports:
//   i_clk, i_reset           clock, synchronous active-low reset
//   i_miss_*, o_miss_ready   miss request handshake and address
//   o_query_idx              set index to lru_4way and the meta array
//   i_victim_*, i_wb_data    victim way/meta/data for o_query_idx
//   i_hit_*, o_hit_ready     hit-path LRU touch
//   o_update_en/o_set_idx/o_accessed_way   LRU update port
//   o_mem_req_*, i_mem_req_ready, i_mem_resp_*   memory side
//   o_fill_*                 fill write into tag/data/meta arrays
//   o_miss_done              one-cycle pulse when the fill happens
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_miss_valid,
  output logic                   o_miss_ready,
  input  logic [TAG_WIDTH-1:0]   i_miss_tag,
  input  logic [INDEX_WIDTH-1:0] i_miss_idx,
  output logic [INDEX_WIDTH-1:0] o_query_idx,
  input  logic [WAY_WIDTH-1:0]   i_victim_way,
  input  logic                   i_victim_dirty,
  input  logic [TAG_WIDTH-1:0]   i_victim_tag,
  input  logic                   i_hit_valid,
  input  logic [INDEX_WIDTH-1:0] i_hit_idx,
  input  logic [WAY_WIDTH-1:0]   i_hit_way,
  output logic                   o_hit_ready,
  output logic                   o_update_en,
  output logic [INDEX_WIDTH-1:0] o_set_idx,
  output logic [WAY_WIDTH-1:0]   o_accessed_way,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic                   o_mem_req_we,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  output logic [LINE_WIDTH-1:0]  o_mem_req_wdata,
  input  logic [LINE_WIDTH-1:0]  i_wb_data,
  input  logic                   i_mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]  i_mem_resp_data,
  output logic                   o_fill_en,
  output logic [INDEX_WIDTH-1:0] o_fill_idx,
  output logic [WAY_WIDTH-1:0]   o_fill_way,
  output logic [TAG_WIDTH-1:0]   o_fill_tag,
  output logic [LINE_WIDTH-1:0]  o_fill_data,
  output logic                   o_miss_done
);

  refill_state_e          r_state;
  refill_state_e          w_state_next;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [WAY_WIDTH-1:0]   r_way;
  logic [TAG_WIDTH-1:0]   r_victim_tag;
  // One line buffer serves both directions: it holds the victim data until
  // the write-back is accepted, and the read data is only captured later.
  logic [LINE_WIDTH-1:0]  r_line;

  assign o_query_idx = r_idx;

  // State register plus the miss/victim/line captures. The victim is frozen
  // in LOOKUP so later hit touches to the same set cannot move the refill.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_idx        <= '0;
      r_way        <= '0;
      r_victim_tag <= '0;
      r_line       <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (i_miss_valid) begin
            r_tag <= i_miss_tag;
            r_idx <= i_miss_idx;
          end
        end
        ST_LOOKUP: begin
          r_way        <= i_victim_way;
          r_victim_tag <= i_victim_tag;
          r_line       <= i_wb_data;
        end
        ST_RD_WAIT: begin
          if (i_mem_resp_valid) begin
            r_line <= i_mem_resp_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode. The LRU port follows the hit path in
  // every state except FILL, where the controller reports its own refill.
  // Responses are only looked at in the two WAIT states.
  always_comb begin
    w_state_next    = r_state;
    o_miss_ready    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_we    = 1'b0;
    o_mem_req_addr  = '0;
    o_mem_req_wdata = '0;
    o_fill_en       = 1'b0;
    o_fill_idx      = '0;
    o_fill_way      = '0;
    o_fill_tag      = '0;
    o_fill_data     = '0;
    o_miss_done     = 1'b0;
    o_hit_ready     = 1'b1;
    o_update_en     = i_hit_valid;
    o_set_idx       = i_hit_idx;
    o_accessed_way  = i_hit_way;
    case (r_state)
      ST_IDLE: begin
        o_miss_ready = 1'b1;
        if (i_miss_valid) begin
          w_state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        w_state_next = i_victim_dirty ? ST_WB_REQ : ST_RD_REQ;
      end
      ST_WB_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_we    = 1'b1;
        o_mem_req_addr  = line_addr(r_victim_tag, r_idx);
        o_mem_req_wdata = r_line;
        if (i_mem_req_ready) begin
          w_state_next = ST_WB_WAIT;
        end
      end
      ST_WB_WAIT: begin
        if (i_mem_resp_valid) begin
          w_state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = line_addr(r_tag, r_idx);
        if (i_mem_req_ready) begin
          w_state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (i_mem_resp_valid) begin
          w_state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        o_fill_en      = 1'b1;
        o_fill_idx     = r_idx;
        o_fill_way     = r_way;
        o_fill_tag     = r_tag;
        o_fill_data    = r_line;
        o_hit_ready    = 1'b0;
        o_update_en    = 1'b1;
        o_set_idx      = r_idx;
        o_accessed_way = r_way;
        o_miss_done    = 1'b1;
        w_state_next   = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl
// Self-checking bench for cache_refill_ctrl. The bench plays the LRU block
// (per-set recency order), the meta/data arrays and main memory, and
// predicts every transaction of a miss from those contents.
module tb_cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
;

  logic                   clk;
  logic                   reset;
  logic                   missValid;
  logic                   missReady;
  logic [TAG_WIDTH-1:0]   missTag;
  logic [INDEX_WIDTH-1:0] missIdx;
  logic [INDEX_WIDTH-1:0] queryIdx;
  logic [WAY_WIDTH-1:0]   victimWay;
  logic                   victimDirty;
  logic [TAG_WIDTH-1:0]   victimTag;
  logic                   hitValid;
  logic [INDEX_WIDTH-1:0] hitIdx;
  logic [WAY_WIDTH-1:0]   hitWay;
  logic                   hitReady;
  logic                   updateEn;
  logic [INDEX_WIDTH-1:0] setIdx;
  logic [WAY_WIDTH-1:0]   accessedWay;
  logic                   memReqValid;
  logic                   memReqReady;
  logic                   memReqWe;
  logic [ADDR_WIDTH-1:0]  memReqAddr;
  logic [LINE_WIDTH-1:0]  memReqWdata;
  logic [LINE_WIDTH-1:0]  wbData;
  logic                   memRespValid;
  logic [LINE_WIDTH-1:0]  memRespData;
  logic                   fillEn;
  logic [INDEX_WIDTH-1:0] fillIdx;
  logic [WAY_WIDTH-1:0]   fillWay;
  logic [TAG_WIDTH-1:0]   fillTag;
  logic [LINE_WIDTH-1:0]  fillData;
  logic                   missDone;

  // Environment model: index 0 of lruOrder is the least recently used way.
  logic [WAY_WIDTH-1:0]   lruOrder  [128][4];
  logic                   metaDirty [128][4];
  logic [TAG_WIDTH-1:0]   metaTag   [128][4];
  logic [LINE_WIDTH-1:0]  dataArr   [128][4];

  int compared   = 0;
  int mismatched = 0;

  cache_refill_ctrl dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_miss_valid    (missValid),
    .o_miss_ready    (missReady),
    .i_miss_tag      (missTag),
    .i_miss_idx      (missIdx),
    .o_query_idx     (queryIdx),
    .i_victim_way    (victimWay),
    .i_victim_dirty  (victimDirty),
    .i_victim_tag    (victimTag),
    .i_hit_valid     (hitValid),
    .i_hit_idx       (hitIdx),
    .i_hit_way       (hitWay),
    .o_hit_ready     (hitReady),
    .o_update_en     (updateEn),
    .o_set_idx       (setIdx),
    .o_accessed_way  (accessedWay),
    .o_mem_req_valid (memReqValid),
    .i_mem_req_ready (memReqReady),
    .o_mem_req_we    (memReqWe),
    .o_mem_req_addr  (memReqAddr),
    .o_mem_req_wdata (memReqWdata),
    .i_wb_data       (wbData),
    .i_mem_resp_valid(memRespValid),
    .i_mem_resp_data (memRespData),
    .o_fill_en       (fillEn),
    .o_fill_idx      (fillIdx),
    .o_fill_way      (fillWay),
    .o_fill_tag      (fillTag),
    .o_fill_data     (fillData),
    .o_miss_done     (missDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The LRU block and meta/data arrays answer combinationally for the
  // set the controller is querying.
  always_comb begin
    victimWay   = lruOrder[queryIdx][0];
    victimDirty = metaDirty[queryIdx][victimWay];
    victimTag   = metaTag[queryIdx][victimWay];
    wbData      = dataArr[queryIdx][victimWay];
  end

  // Contents of main memory for a line address.
  function automatic logic [LINE_WIDTH-1:0] memLine(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return {x * 32'h9E3779B1, x ^ 32'hDEADBEEF, x + 32'h01234567, ~x};
  endfunction

  function automatic logic [LINE_WIDTH-1:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Make a way most recently used.
  function automatic void touch(input int s, input logic [WAY_WIDTH-1:0] w);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (lruOrder[s][i] == w) p = i;
    for (int i = p; i < 3; i++) lruOrder[s][i] = lruOrder[s][i+1];
    lruOrder[s][3] = w;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // mode 0: no hits, 1: the directed set-12/way-3 hit when 'special',
  // 2: random hit traffic.
  task automatic applyStimulus(input int mode, input bit special);
    if (mode == 2) begin
      hitValid = 1'($urandom_range(0, 1));
      hitIdx   = 7'($urandom);
      hitWay   = 2'($urandom);
    end else if (mode == 1 && special) begin
      hitValid = 1'b1;
      hitIdx   = 7'd12;
      hitWay   = 2'd3;
    end else begin
      hitValid = 1'b0;
      hitIdx   = '0;
      hitWay   = '0;
    end
  endtask

  task automatic checkFwd(input string tag);
    checkOutput({tag, "_hit_ready"}, 128'(hitReady), 128'(1'b1));
    checkOutput({tag, "_update_en"}, 128'(updateEn), 128'(hitValid));
    if (hitValid) begin
      checkOutput({tag, "_set_idx"}, 128'(setIdx), 128'(hitIdx));
      checkOutput({tag, "_acc_way"}, 128'(accessedWay), 128'(hitWay));
    end
  endtask

  // Advance past the rising edge; an accepted hit then updates LRU order.
  task automatic tick(input bit hitAccepted);
    @(posedge clk);
    #1;
    if (hitAccepted && hitValid) touch(int'(hitIdx), hitWay);
  endtask

  // One complete miss, checked cycle by cycle.
  task automatic runMiss(input logic [TAG_WIDTH-1:0] tag, input logic [INDEX_WIDTH-1:0] idx,
                         input int readyDelay, input int respDelay, input int hitMode,
                         input bit resetInWb);
    logic [WAY_WIDTH-1:0]  expWay;
    logic                  expDirty;
    logic [TAG_WIDTH-1:0]  expVtag;
    logic [LINE_WIDTH-1:0] expWdata;
    logic [LINE_WIDTH-1:0] expRdata;

    @(negedge clk);
    missValid = 1'b1; missTag = tag; missIdx = idx;
    applyStimulus(hitMode, 1'b0);
    #1;
    checkOutput("idle_miss_ready", 128'(missReady), 128'(1'b1));
    checkFwd("idle");
    tick(1'b1);

    @(negedge clk);
    missValid = 1'b0; missTag = 19'($urandom); missIdx = 7'($urandom);
    applyStimulus(hitMode, 1'b0);
    expWay   = lruOrder[idx][0];
    expDirty = metaDirty[idx][expWay];
    expVtag  = metaTag[idx][expWay];
    expWdata = dataArr[idx][expWay];
    expRdata = memLine({tag, idx});
    #1;
    checkOutput("lookup_miss_ready", 128'(missReady), 128'(1'b0));
    checkOutput("lookup_query_idx", 128'(queryIdx), 128'(idx));
    checkOutput("lookup_req_valid", 128'(memReqValid), 128'(1'b0));
    checkFwd("lookup");
    tick(1'b1);

    if (expDirty) begin
      for (int c = 0; c <= readyDelay; c++) begin
        @(negedge clk);
        memReqReady = (c == readyDelay);
        memRespValid = (c == readyDelay);
        memRespData = randLine();
        applyStimulus(hitMode, 1'b0);
        #1;
        checkOutput("wb_req_valid", 128'(memReqValid), 128'(1'b1));
        checkOutput("wb_req_we", 128'(memReqWe), 128'(1'b1));
        checkOutput("wb_req_addr", 128'(memReqAddr), 128'({expVtag, idx}));
        checkOutput("wb_req_wdata", memReqWdata, expWdata);
        checkOutput("wb_miss_ready", 128'(missReady), 128'(1'b0));
        checkFwd("wb_req");
        tick(1'b1);
      end
      for (int c = 0; c <= respDelay; c++) begin
        @(negedge clk);
        memReqReady = 1'($urandom_range(0, 1));
        memRespValid = (c == respDelay);
        if (resetInWb) begin
          reset = 1'b0;
          memRespValid = 1'b0;
          applyStimulus(0, 1'b0);
        end else begin
          applyStimulus(hitMode, 1'b0);
        end
        #1;
        checkOutput("wbw_req_valid", 128'(memReqValid), 128'(1'b0));
        checkOutput("wbw_fill_en", 128'(fillEn), 128'(1'b0));
        if (!resetInWb) checkFwd("wb_wait");
        tick(!resetInWb);
        if (resetInWb) begin
          @(negedge clk);
          reset = 1'b1;
          memReqReady = 1'b0;
          #1;
          checkOutput("rst_mid_miss_ready", 128'(missReady), 128'(1'b1));
          checkOutput("rst_mid_fill_en", 128'(fillEn), 128'(1'b0));
          checkOutput("rst_mid_miss_done", 128'(missDone), 128'(1'b0));
          checkOutput("rst_mid_req_valid", 128'(memReqValid), 128'(1'b0));
          return;
        end
      end
    end

    for (int c = 0; c <= readyDelay; c++) begin
      @(negedge clk);
      memReqReady = (c == readyDelay);
      memRespValid = (c == readyDelay);
      memRespData = randLine();
      applyStimulus(hitMode, 1'b0);
      #1;
      checkOutput("rd_req_valid", 128'(memReqValid), 128'(1'b1));
      checkOutput("rd_req_we", 128'(memReqWe), 128'(1'b0));
      checkOutput("rd_req_addr", 128'(memReqAddr), 128'({tag, idx}));
      checkOutput("rd_miss_ready", 128'(missReady), 128'(1'b0));
      checkFwd("rd_req");
      tick(1'b1);
    end
    for (int c = 0; c <= respDelay; c++) begin
      @(negedge clk);
      memReqReady = 1'($urandom_range(0, 1));
      memRespValid = (c == respDelay);
      memRespData = (c == respDelay) ? expRdata : randLine();
      applyStimulus(hitMode, c == 0);
      #1;
      checkOutput("rdw_req_valid", 128'(memReqValid), 128'(1'b0));
      checkOutput("rdw_fill_en", 128'(fillEn), 128'(1'b0));
      checkOutput("rdw_miss_done", 128'(missDone), 128'(1'b0));
      checkFwd("rd_wait");
      tick(1'b1);
    end

    @(negedge clk);
    memReqReady = 1'b0;
    memRespValid = 1'($urandom_range(0, 1));
    memRespData = randLine();
    applyStimulus(hitMode, 1'b1);
    #1;
    checkOutput("fill_en", 128'(fillEn), 128'(1'b1));
    checkOutput("fill_idx", 128'(fillIdx), 128'(idx));
    checkOutput("fill_way", 128'(fillWay), 128'(expWay));
    checkOutput("fill_tag", 128'(fillTag), 128'(tag));
    checkOutput("fill_data", fillData, expRdata);
    checkOutput("fill_update_en", 128'(updateEn), 128'(1'b1));
    checkOutput("fill_set_idx", 128'(setIdx), 128'(idx));
    checkOutput("fill_acc_way", 128'(accessedWay), 128'(expWay));
    checkOutput("fill_miss_done", 128'(missDone), 128'(1'b1));
    checkOutput("fill_hit_ready", 128'(hitReady), 128'(1'b0));
    checkOutput("fill_req_valid", 128'(memReqValid), 128'(1'b0));
    tick(1'b0);
    touch(int'(idx), expWay);
    metaTag[idx][expWay]   = tag;
    metaDirty[idx][expWay] = 1'b0;
    dataArr[idx][expWay]   = expRdata;

    @(negedge clk);
    memRespValid = 1'b0;
    applyStimulus(0, 1'b0);
    #1;
    checkOutput("post_miss_done", 128'(missDone), 128'(1'b0));
    checkOutput("post_fill_en", 128'(fillEn), 128'(1'b0));
    checkOutput("post_miss_ready", 128'(missReady), 128'(1'b1));
  endtask

  initial begin
    logic [INDEX_WIDTH-1:0] rIdx;
    for (int s = 0; s < 128; s++) begin
      for (int w = 0; w < 4; w++) begin
        lruOrder[s][w]  = 2'(w);
        metaDirty[s][w] = 1'b0;
        metaTag[s][w]   = '0;
        dataArr[s][w]   = '0;
      end
    end
    reset = 1'b0;
    missValid = 1'b0; missTag = '0; missIdx = '0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
    hitValid = 1'b1; hitIdx = 7'd5; hitWay = 2'd1;

    // Reset state, with a hit forward visible through it.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_miss_ready", 128'(missReady), 128'(1'b1));
    checkOutput("rst_req_valid", 128'(memReqValid), 128'(1'b0));
    checkOutput("rst_req_addr", 128'(memReqAddr), 128'(0));
    checkOutput("rst_fill_en", 128'(fillEn), 128'(1'b0));
    checkOutput("rst_miss_done", 128'(missDone), 128'(1'b0));
    checkOutput("rst_query_idx", 128'(queryIdx), 128'(0));
    checkOutput("rst_update_en", 128'(updateEn), 128'(1'b1));
    checkOutput("rst_set_idx", 128'(setIdx), 128'(5));
    hitValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Clean miss, set 3, victim way 2.
    lruOrder[3] = '{2'd2, 2'd0, 2'd1, 2'd3};
    runMiss(19'h155, 7'd3, 0, 0, 0, 1'b0);

    // Dirty miss, set 127, victim way 1 with tag 0x7A.
    lruOrder[127] = '{2'd1, 2'd0, 2'd2, 2'd3};
    metaDirty[127][1] = 1'b1;
    metaTag[127][1]   = 19'h7A;
    dataArr[127][1]   = randLine();
    runMiss(19'($urandom), 7'd127, 0, 0, 0, 1'b0);

    // Backpressure on a clean and on a dirty miss.
    runMiss(19'($urandom), 7'd20, 5, 2, 0, 1'b0);
    metaDirty[21][0] = 1'b1;
    metaTag[21][0]   = 19'h3_1234;
    dataArr[21][0]   = randLine();
    runMiss(19'($urandom), 7'd21, 5, 1, 0, 1'b0);

    // Hit forwarding in RD_WAIT and blocked in FILL.
    runMiss(19'($urandom), 7'd40, 0, 1, 1, 1'b0);

    // Reset in WB_WAIT, then a normal miss.
    metaDirty[60][0] = 1'b1;
    metaTag[60][0]   = 19'h00ABC;
    dataArr[60][0]   = randLine();
    runMiss(19'($urandom), 7'd60, 0, 2, 0, 1'b1);
    runMiss(19'($urandom), 7'd61, 1, 1, 0, 1'b0);

    // Four clean misses into untouched set 47 fill ways 0..3 in turn.
    for (int i = 0; i < 4; i++) runMiss(19'($urandom), 7'd47, 0, 0, 0, 1'b0);

    // Random misses with random dirty lines, delays and hit traffic.
    for (int n = 0; n < 25; n++) begin
      rIdx = 7'($urandom);
      for (int w = 0; w < 4; w++) begin
        metaDirty[rIdx][w] = 1'($urandom_range(0, 1));
        metaTag[rIdx][w]   = 19'($urandom);
        dataArr[rIdx][w]   = randLine();
      end
      runMiss(19'($urandom), rIdx, $urandom_range(0, 3), $urandom_range(0, 3), 2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling and replacement controller for the 4-way set-associative cache. It is the consumer and driver of the `lru_4way` interface: it queries a set's victim, writes back the victim line to memory if it is dirty, and fetches the missing line. It then fills the chosen way and reports the access back to `lru_4way` so that way becomes most-recently-used. While idle or busy, it forwards hit-path LRU updates from the lookup pipeline.

## Interface
- `INDEX_WIDTH`, from `cache_defs.vh` (7): set index width; 128 sets.
- `TAG_WIDTH`, from `cache_defs.vh` (19): tag width.
- `LINE_WIDTH`, from `cache_defs.vh` (128): cache line width in bits.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset. Clears state when sampled low at a rising edge.
- `miss_valid` / `miss_ready`  in / out  1 / 1  miss request handshake.
- `miss_tag`, `miss_idx`  in  TAG_WIDTH, INDEX_WIDTH  address of the missing line.
- `query_idx`  out  INDEX_WIDTH  driven to `lru_4way.query_idx` and to the meta array.
- `victim_way`  in  2  combinational from `lru_4way`.
- `victim_dirty`, `victim_tag`  in  1, TAG_WIDTH  combinational meta-array read at (`query_idx`, `victim_way`).
- `hit_valid`, `hit_idx`, `hit_way`  in  1, INDEX_WIDTH, 2  hit-path LRU touch.
- `hit_ready`  out  1  hit touch accepted this cycle.
- `update_en`, `set_idx`, `accessed_way`  out  1, INDEX_WIDTH, 2  to `lru_4way`.
- `mem_req_valid` / `mem_req_ready`  out / in  1 / 1  memory request handshake.
- `mem_req_we`, `mem_req_addr`, `mem_req_wdata`  out  1, TAG_WIDTH+INDEX_WIDTH, LINE_WIDTH  request write flag, line address {tag, idx}, and write data.
- `wb_data`  in  LINE_WIDTH  victim line data from the data array, valid during the LOOKUP state.
- `mem_resp_valid`, `mem_resp_data`  in  1, LINE_WIDTH  write acknowledge, or read data.
- `fill_en`, `fill_idx`, `fill_way`, `fill_tag`, `fill_data`  out  fill write into the tag, data and meta arrays. A fill sets valid and clears dirty.
- `miss_done`  out  1  one-cycle pulse when the fill completes.

## Operation
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, FILL.
- **IDLE:**
  - `miss_ready`=1.
  - On `miss_valid`, latch `miss_tag`/`miss_idx` and go to LOOKUP.
- **LOOKUP** (1 cycle):
  - `query_idx`=latched idx.
  - Latch `victim_way`, `victim_dirty`, `victim_tag` and `wb_data`.
  - If dirty, go to WB_REQ; otherwise go to RD_REQ.
- **WB_REQ:**
  - `mem_req_valid`=1, `we`=1, `addr`={victim_tag, idx}, `wdata`=latched line.
  - On `mem_req_ready`, go to WB_WAIT.
- **WB_WAIT:** on `mem_resp_valid`, go to RD_REQ.
- **RD_REQ:**
  - `mem_req_valid`=1, `we`=0, `addr`={miss_tag, idx}.
  - On `mem_req_ready`, go to RD_WAIT.
- **RD_WAIT:** on `mem_resp_valid`, latch `mem_resp_data` and go to FILL.
- **FILL** (1 cycle):
  - `fill_en`=1 with latched idx/way/tag/data.
  - `update_en`=1, `set_idx`=idx, `accessed_way`=latched victim.
  - `miss_done`=1.
  - Next state IDLE.
- **LRU port mux:**
  - In FILL, the controller owns the LRU port, and `hit_ready`=0.
  - In all other states, `hit_ready`=1 and `update_en`=`hit_valid`, with `set_idx`/`accessed_way` taken from `hit_idx`/`hit_way`.
- The victim is latched in LOOKUP. Later hit touches to the same set do not change the way being refilled.

## Timing
- All outputs are registered state decodes or mux outputs.
- Reset: state is IDLE and `miss_ready`=1. Every other output is 0, or follows the hit forward (`update_en`=`hit_valid`). All latches are cleared to 0.
- Clean miss, with ready asserted in RD_REQ and response 1 cycle later: accept at cycle 0, then LOOKUP at 1, RD_REQ at 2, RD_WAIT at 3, FILL/`miss_done` at 4.
- A dirty miss adds a minimum of 2 cycles (WB_REQ, WB_WAIT).
- `mem_req_valid` is never retracted before `mem_req_ready`; `addr`, `we` and `wdata` stay stable while waiting.
- `mem_resp_valid` outside WB_WAIT or RD_WAIT is ignored.
- `miss_ready`=0 in every non-IDLE state; one outstanding miss at a time.
- A response arriving in the same cycle the request is accepted is not consumed. Responses are sampled only in the WAIT states.
- Reset low mid-operation returns to IDLE on that edge, with no `fill_en` or `miss_done`. The memory side must be reset together with this block.

## Structure
- `cache_defs.vh` holds the constants `INDEX_WIDTH`, `TAG_WIDTH`, `LINE_WIDTH` and `WAYS`, plus the state encodings.
- No sub-modules. `lru_4way` is instantiated beside this block in `cache_top`, not inside it.

## Test plan
- **Clean miss, set 3:** tag 0x155, victim way 2 clean, `mem_req_ready` held 1, response 1 cycle after acceptance.
  - Expect a read request with addr={0x155,3}.
  - Expect `fill_en` with way 2 and `update_en` with `accessed_way`=2 at cycle 4, plus a single `miss_done` pulse.
- **Dirty miss, set 127:** victim way 1 has `victim_tag` 0x7A and is dirty.
  - Expect a write with addr={0x7A,127} and `we`=1 first.
  - Expect the read only after the write ack, then the fill into way 1.
- **Backpressure:** `mem_req_ready` held low for 5 cycles.
  - `mem_req_valid` and `addr` stay stable throughout.
  - Exactly one request is accepted.
- **Hit forwarding:** a hit on set 12 way 3 during RD_WAIT produces `update_en`=1, `set_idx`=12, `accessed_way`=3 in the same cycle. A hit asserted during FILL sees `hit_ready`=0.
- **Reset mid-WB_WAIT:** drive `reset`=0 for 1 cycle.
  - The block returns to IDLE with `miss_ready`=1.
  - No `fill_en` or `miss_done`.
  - The next miss completes normally.
- **LRU integration, set 47:** with `lru_4way` at reset ages, four consecutive clean misses fill ways 0, 1, 2, 3 in that order.
